// File: rtl/ak4619_tdm_target.sv
// ak4619_tdm_target
//   Emulates the CODEC end of the AK4619 TDM link. The master drives bick and
//   lrck; this block locks to the frame, deserializes DAC slots from sdin1 and
//   serializes ADC words onto sdout1.
//
// Ports
//   clk, rst              block clock (>= 4x bick), synchronous active-high reset
//   bick, lrck, sdin1     link inputs from the master, asynchronous to clk
//   sdout1                serial ADC data back to the master
//   sample_out0..3        received DAC words, one per slot, raw bit transport
//   sample_valid          one-clk pulse when sample_out0..3 update
//   sample_in0..3         ADC words to transmit, latched once per frame
//   locked                frame alignment established
//   frame_err             one-clk pulse on a misplaced lrck rise while locked
module ak4619_tdm_target #(
  parameter int W       = 16,
  parameter int SLOT_W  = 32,
  parameter int N_SLOTS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bick,
  input  logic         lrck,
  input  logic         sdin1,
  output logic         sdout1,
  output logic [W-1:0] sample_out0,
  output logic [W-1:0] sample_out1,
  output logic [W-1:0] sample_out2,
  output logic [W-1:0] sample_out3,
  output logic         sample_valid,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  output logic         locked,
  output logic         frame_err
);

  localparam int F       = SLOT_W * N_SLOTS;
  localparam int B_W     = $clog2(F + 1);
  localparam int N_PORTS = 4;
  localparam logic [B_W-1:0] LAST_IDX = B_W'(F - 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Input synchronizers; the third bick stage only serves edge detection.
  logic bick_meta_reg, bick_sync_reg, bick_dly_reg;
  logic lrck_meta_reg, lrck_sync_reg;
  logic sdin_meta_reg, sdin_sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      bick_meta_reg <= 1'b0;
      bick_sync_reg <= 1'b0;
      bick_dly_reg  <= 1'b0;
      lrck_meta_reg <= 1'b0;
      lrck_sync_reg <= 1'b0;
      sdin_meta_reg <= 1'b0;
      sdin_sync_reg <= 1'b0;
    end else begin
      bick_meta_reg <= bick;
      bick_sync_reg <= bick_meta_reg;
      bick_dly_reg  <= bick_sync_reg;
      lrck_meta_reg <= lrck;
      lrck_sync_reg <= lrck_meta_reg;
      sdin_meta_reg <= sdin1;
      sdin_sync_reg <= sdin_meta_reg;
    end
  end

  logic rise, fall;
  assign rise = bick_sync_reg & ~bick_dly_reg;
  assign fall = ~bick_sync_reg & bick_dly_reg;

  // b_reg holds the index of the most recent rise.
  logic [B_W-1:0] b_reg;
  logic           lrck_prev_reg;
  logic [1:0]     state_reg;
  logic           sample_valid_reg;
  logic           frame_err_reg;
  logic           sdout1_reg;

  logic           sync_ev;
  logic           well_placed;
  logic [B_W-1:0] idx_wrap;
  logic [B_W-1:0] idx_next;
  logic [B_W-1:0] rx_slot, rx_pos;
  logic [B_W-1:0] tx_slot, tx_pos;
  logic [1:0]     state_next;
  logic           err_next;
  logic           frame_end;
  logic           commit;

  logic [N_PORTS*W-1:0] sample_in_flat;
  logic [N_PORTS*W-1:0] tx_shadow_flat;
  logic [N_PORTS*W-1:0] rx_word_flat;
  logic [W-1:0]         tx_word;
  logic [W-1:0]         tx_shift;
  logic                 tx_bit;

  assign sample_in_flat = {sample_in3, sample_in2, sample_in1, sample_in0};

  always_comb begin
    sync_ev     = rise & lrck_sync_reg & ~lrck_prev_reg;
    // A sync is correctly placed when the free-running index would wrap to 0.
    well_placed = (b_reg == LAST_IDX);
    idx_wrap    = well_placed ? '0 : b_reg + B_W'(1);
    idx_next    = sync_ev ? '0 : idx_wrap;

    rx_slot = idx_next / B_W'(SLOT_W);
    rx_pos  = idx_next % B_W'(SLOT_W);

    state_next = state_reg;
    err_next   = 1'b0;
    if (sync_ev) begin
      case (state_reg)
        ST_HUNT:   state_next = ST_ALIGN;
        ST_ALIGN:  if (well_placed) state_next = ST_LOCKED;
        ST_LOCKED: begin
          if (!well_placed) begin
            state_next = ST_ALIGN;
            err_next   = 1'b1;
          end
        end
        default:   state_next = ST_HUNT;
      endcase
    end

    frame_end = rise & (idx_next == LAST_IDX);
    commit    = frame_end & (state_reg == ST_LOCKED);

    // On a fall, drive the bit the master will sample at the next rise.
    tx_slot = idx_wrap / B_W'(SLOT_W);
    tx_pos  = idx_wrap % B_W'(SLOT_W);
    tx_word = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (tx_slot == B_W'(i)) tx_word = tx_shadow_flat[i*W +: W];
    end
    tx_shift = tx_word << tx_pos;
    tx_bit   = (tx_pos < B_W'(W)) ? tx_shift[W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_reg            <= '0;
      lrck_prev_reg    <= 1'b0;
      state_reg        <= ST_HUNT;
      sample_valid_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
      sdout1_reg       <= 1'b0;
    end else begin
      sample_valid_reg <= commit;
      frame_err_reg    <= err_next;
      if (rise) begin
        b_reg         <= idx_next;
        lrck_prev_reg <= lrck_sync_reg;
        state_reg     <= state_next;
      end
      // Silence the line as soon as alignment is lost.
      if (state_next != ST_LOCKED) begin
        sdout1_reg <= 1'b0;
      end else if (fall) begin
        sdout1_reg <= tx_bit;
      end
    end
  end

  // Per-slot receive shifter, committed word and transmit shadow.
  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_slot
      logic [W-1:0] rx_shift_reg;
      logic [W-1:0] rx_shift_next;
      logic [W-1:0] rx_word_reg;
      logic [W-1:0] tx_shadow_reg;

      always_comb begin
        rx_shift_next = rx_shift_reg;
        if (rise && rx_slot == B_W'(gi) && rx_pos < B_W'(W)) begin
          rx_shift_next = (rx_shift_reg << 1) | W'(sdin_sync_reg);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rx_shift_reg  <= '0;
          rx_word_reg   <= '0;
          tx_shadow_reg <= '0;
        end else begin
          rx_shift_reg <= rx_shift_next;
          // Commit includes the bit shifted on this same rise.
          if (commit) rx_word_reg <= rx_shift_next;
          if (frame_end) tx_shadow_reg <= sample_in_flat[gi*W +: W];
        end
      end

      assign rx_word_flat[gi*W +: W]   = rx_word_reg;
      assign tx_shadow_flat[gi*W +: W] = tx_shadow_reg;
    end
  endgenerate

  assign sample_out0  = rx_word_flat[0*W +: W];
  assign sample_out1  = rx_word_flat[1*W +: W];
  assign sample_out2  = rx_word_flat[2*W +: W];
  assign sample_out3  = rx_word_flat[3*W +: W];
  assign sample_valid = sample_valid_reg;
  assign frame_err    = frame_err_reg;
  assign locked       = (state_reg == ST_LOCKED);
  assign sdout1       = sdout1_reg;

endmodule

// File: tb/tb_ak4619_tdm_target.sv
module tb_ak4619_tdm_target;

  logic        clk;
  logic        rst;
  logic        bick;
  logic        lrck;
  logic        sdin1;
  logic        sdout1;
  logic [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic        sample_valid;
  logic [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic        locked;
  logic        frame_err;

  ak4619_tdm_target #(.W(16), .SLOT_W(32), .N_SLOTS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bick         (bick),
    .lrck         (lrck),
    .sdin1        (sdin1),
    .sdout1       (sdout1),
    .sample_out0  (sample_out0),
    .sample_out1  (sample_out1),
    .sample_out2  (sample_out2),
    .sample_out3  (sample_out3),
    .sample_valid (sample_valid),
    .sample_in0   (sample_in0),
    .sample_in1   (sample_in1),
    .sample_in2   (sample_in2),
    .sample_in3   (sample_in3),
    .locked       (locked),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int sv_cnt = 0;
  int fe_cnt = 0;
  int pad_bad = 0;

  logic [15:0] m_word [4];
  logic [15:0] r_word [4];

  // Pulse counters: one count per clk cycle the output is high.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) sv_cnt <= sv_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_master(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    m_word[0] = a;
    m_word[1] = b;
    m_word[2] = c;
    m_word[3] = d;
  endtask

  // One 128-bit frame at bick = clk/8. inj_pos adds a stray lrck pulse,
  // chg_pos rewrites sample_in0, rst_pos pulses reset for 2 clk (-1 = none).
  task automatic run_frame(input int inj_pos, input int chg_pos,
                           input logic [15:0] chg_val, input int rst_pos);
    for (int b = 0; b < 128; b++) begin
      logic [6:0]  bv;
      logic [1:0]  s;
      logic [4:0]  p;
      logic [15:0] tmp;
      logic        dout;
      bv  = b[6:0];
      s   = bv[6:5];
      p   = bv[4:0];
      tmp = m_word[s] << p[3:0];
      bick  = 1'b0;
      lrck  = (b == 0 || b == inj_pos);
      sdin1 = (p < 5'd16) ? tmp[15] : 1'b0;
      if (b == chg_pos) sample_in0 = chg_val;
      if (b == rst_pos) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      dout = sdout1;
      if (p < 5'd16) r_word[s] = {r_word[s][14:0], dout};
      else if (dout !== 1'b0) pad_bad++;
      bick = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    bick = 1'b0;
    lrck = 1'b0;
    sdin1 = 1'b0;
    sample_in0 = 16'hA5A5;
    sample_in1 = 16'h0001;
    sample_in2 = 16'h8000;
    sample_in3 = 16'h5A5A;
    for (int i = 0; i < 4; i++) r_word[i] = 16'h0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_sdout1", 32'(sdout1), 32'h0);
    check("reset_out0", 32'(sample_out0), 32'h0);
    check("reset_out1", 32'(sample_out1), 32'h0);
    check("reset_out2", 32'(sample_out2), 32'h0);
    check("reset_out3", 32'(sample_out3), 32'h0);
    check("reset_valid", 32'(sample_valid), 32'h0);
    check("reset_locked", 32'(locked), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);

    // Frame A: first sync moves HUNT -> ALIGN only.
    set_master(16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF);
    run_frame(-1, -1, 16'h0, -1);
    check("A_locked", 32'(locked), 32'h0);
    check("A_valid_cnt", sv_cnt, 0);

    // Frame B: correctly spaced sync locks; this frame commits.
    run_frame(-1, -1, 16'h0, -1);
    check("B_locked", 32'(locked), 32'h1);
    check("B_valid_cnt", sv_cnt, 1);
    check("B_out0", 32'(sample_out0), 32'h1234);
    check("B_out1", 32'(sample_out1), 32'h8000);
    check("B_out2", 32'(sample_out2), 32'h7FFF);
    check("B_out3", 32'(sample_out3), 32'hFFFF);

    // Frame C: full TX frame; sample_in0 changes mid-frame to 0x1111.
    pad_bad = 0;
    run_frame(-1, 40, 16'h1111, -1);
    check("C_tx0", 32'(r_word[0]), 32'hA5A5);
    check("C_tx1", 32'(r_word[1]), 32'h0001);
    check("C_tx2", 32'(r_word[2]), 32'h8000);
    check("C_tx3", 32'(r_word[3]), 32'h5A5A);
    check("C_pad_bits", pad_bad, 0);
    check("C_valid_cnt", sv_cnt, 2);
    check("C_frame_err_cnt", fe_cnt, 0);

    // Frame D: new RX pattern; carries 0x1111; sample_in0 -> 0x2222 at b=40.
    set_master(16'h0F0F, 16'h0001, 16'hAAAA, 16'h5555);
    run_frame(-1, 40, 16'h2222, -1);
    check("D_tx0", 32'(r_word[0]), 32'h1111);
    check("D_out0", 32'(sample_out0), 32'h0F0F);
    check("D_out1", 32'(sample_out1), 32'h0001);
    check("D_out2", 32'(sample_out2), 32'hAAAA);
    check("D_out3", 32'(sample_out3), 32'h5555);
    check("D_valid_cnt", sv_cnt, 3);

    // Frame E: carries 0x2222.
    set_master(16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF);
    run_frame(-1, -1, 16'h0, -1);
    check("E_tx0", 32'(r_word[0]), 32'h2222);
    check("E_tx3", 32'(r_word[3]), 32'h5A5A);
    check("E_out0", 32'(sample_out0), 32'h1234);
    check("E_valid_cnt", sv_cnt, 4);

    // Frame F: stray lrck at b=60 -> frame_err, unlock, no commit.
    run_frame(60, -1, 16'h0, -1);
    check("F_frame_err_cnt", fe_cnt, 1);
    check("F_locked", 32'(locked), 32'h0);
    check("F_valid_cnt", sv_cnt, 4);

    // Frame G: sync now misplaced relative to realigned index; stays ALIGN, line silent.
    run_frame(-1, -1, 16'h0, -1);
    check("G_locked", 32'(locked), 32'h0);
    check("G_valid_cnt", sv_cnt, 4);
    check("G_tx_silent", 32'(r_word[0] | r_word[1] | r_word[2] | r_word[3]), 32'h0);

    // Frame H: correctly spaced sync relocks.
    set_master(16'hBEEF, 16'h0000, 16'h0F0F, 16'h8001);
    run_frame(-1, -1, 16'h0, -1);
    check("H_locked", 32'(locked), 32'h1);
    check("H_valid_cnt", sv_cnt, 5);
    check("H_out0", 32'(sample_out0), 32'hBEEF);
    check("H_out3", 32'(sample_out3), 32'h8001);

    // Frame I: reset at b=70 clears everything.
    run_frame(-1, -1, 16'h0, 70);
    check("I_out0", 32'(sample_out0), 32'h0);
    check("I_out1", 32'(sample_out1), 32'h0);
    check("I_out2", 32'(sample_out2), 32'h0);
    check("I_out3", 32'(sample_out3), 32'h0);
    check("I_locked", 32'(locked), 32'h0);
    check("I_sdout1", 32'(sdout1), 32'h0);
    check("I_valid_cnt", sv_cnt, 5);

    // Frame J: HUNT -> ALIGN, no output yet.
    set_master(16'h0F0F, 16'h0001, 16'hAAAA, 16'h5555);
    run_frame(-1, -1, 16'h0, -1);
    check("J_locked", 32'(locked), 32'h0);
    check("J_valid_cnt", sv_cnt, 5);

    // Frame K: ALIGN -> LOCKED, commit again.
    run_frame(-1, -1, 16'h0, -1);
    check("K_locked", 32'(locked), 32'h1);
    check("K_valid_cnt", sv_cnt, 6);
    check("K_out0", 32'(sample_out0), 32'h0F0F);
    check("K_out2", 32'(sample_out2), 32'hAAAA);
    check("K_frame_err_cnt", fe_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ak4619_tdm_target.md
Name: ak4619_tdm_target

Overview:
- Synthesizable emulation of the CODEC end of the TDM serial link: the target side of the same link the ak4619 driver masters.
- Accepts externally driven bick/lrck, deserializes DAC slot data from sdin1, and serializes ADC sample words onto sdout1.
- Used for loopback bring-up (eurorack_pmod wired to an FPGA-side fake CODEC) and hardware-in-the-loop regression without the AK4619 fitted.

Parameters:
- W, 16, sample width in bits; W <= SLOT_W.
- SLOT_W, 32, bick periods per TDM slot.
- N_SLOTS, 4, slots per frame; frame length F = SLOT_W*N_SLOTS (128 at defaults).

Ports:
- clk  in  1  block clock; must be >= 4x the bick frequency.
- rst  in  1  synchronous, active-high reset.
- bick  in  1  bit clock from master, asynchronous to clk.
- lrck  in  1  frame sync from master, asynchronous to clk.
- sdin1  in  1  serial DAC data from master.
- sdout1  out  1  serial ADC data to master.
- sample_out0..3  out  W each  deserialized DAC words for slots 0..3, signed.
- sample_valid  out  1  one-clk pulse when sample_out0..3 update.
- sample_in0..3  in  W each  ADC words to transmit in slots 0..3, signed.
- locked  out  1  frame alignment established.
- frame_err  out  1  one-clk pulse on a misplaced lrck rise.

Behaviour:
- Reset: sdout1=0, sample_out*=0, sample_valid=0, locked=0, frame_err=0, bit index b=0, shift registers 0, sync history cleared. Reset asserted mid-frame aborts the frame immediately; relock is required afterwards.
- Input sync: bick, lrck, and sdin1 each pass through 2-FF synchronizers. Edge detect compares against a third register stage.
  - rise = bick edge 0->1 (sample event).
  - fall = bick edge 1->0 (drive event).
  - Latency from a pin edge to the event is 3 clk.
- Frame sync: lrck and sdin1 are sampled on each rise. A sync event is a rise where lrck=1 and lrck at the previous rise was 0.
- Bit index:
  - On a sync event, b:=0.
  - Otherwise on each rise, b:=(b+1) mod F.
  - Slot s=b/SLOT_W; position p=b mod SLOT_W.
- Lock FSM, states HUNT, ALIGN, LOCKED:
  - HUNT: first sync event -> ALIGN.
  - ALIGN: a sync event arriving when the predicted index is 0 (b was F-1) -> LOCKED, locked=1. A sync at any other position stays in ALIGN and realigns b.
  - LOCKED: a sync at any index other than predicted 0 -> frame_err pulse (1 clk), locked=0, state ALIGN, b realigned to 0, partial frame discarded. A missing sync while b wraps is tolerated: the free-running index continues and the state stays LOCKED.
- RX:
  - On a rise with p<W, sdin1 shifts MSB-first into the slot s register. Bits with p>=W are ignored.
  - On the rise where b=F-1 and state is LOCKED, all four sample_out are written simultaneously and sample_valid pulses 1 clk after that rise event.
  - No sample_valid is produced in HUNT or ALIGN.
- TX:
  - On the rise where b=F-1, sample_in0..3 are latched into the TX shadow; changes to sample_in at other times do not affect the frame in flight.
  - On each fall, sdout1 := bit for index n=(b+1) mod F: slot n/SLOT_W, MSB-first for p<W, 0 for p>=W.
  - The bit for index b is therefore stable at rise b.
  - sdout1 is forced to 0 whenever locked=0.
- Width rules: samples are pure bit transport with no sign extension, rounding, or inversion.
- Simultaneous sync event and b=F-1: treated as a correctly placed sync. RX commit, TX latch, and index reset all occur.

Test Plan:
- Reset then 3 clean frames (bick=clk/8, lrck high for bick 0 of each 128) -> locked rises at start of frame 2; frame_err never pulses.
- Master sends slots 0x1234, 0x8000, 0x7FFF, 0xFFFF (zeros in p>=16) -> after the locked frame, sample_out0..3 equal those values, with one sample_valid per frame.
- sample_in0..3 = 0xA5A5, 0x0001, 0x8000, 0x5A5A held steady -> master deserializer recovers exactly those words; sdout1=0 for p 16..31 of every slot.
- sample_in changes mid-frame (0x1111 -> 0x2222 at b=40) -> current frame carries 0x1111, next frame carries 0x2222.
- While locked, lrck rise injected at b=60 -> frame_err 1-clk pulse, locked=0, no sample_valid for that frame; relock after the next correctly spaced sync.
- rst asserted at b=70 for 2 clk -> all outputs 0; first sample_valid appears only after a new HUNT->ALIGN->LOCKED sequence.
